// File: rtl/systolic_seq_ctrl_if.sv
// Handshake bundle between the tile sequencer, the weight/activation buffers and the PE array.
// The slave side is the sequencer. The master side is the buffers/array environment.
interface systolic_seq_ctrl_if #(
  parameter int HEIGHT = 32,
  parameter int RW     = 16
);
  logic                      start;
  logic [RW-1:0]             num_rows;
  logic                      busy;
  logic                      done;
  logic                      w_valid;
  logic                      w_rd_en;
  logic [$clog2(HEIGHT)-1:0] w_row;
  logic                      arr_load_w;
  logic                      a_valid;
  logic                      a_rd_en;
  logic                      arr_shift_en;

  modport master (
    output start, num_rows, w_valid, a_valid,
    input  busy, done, w_rd_en, w_row, arr_load_w, a_rd_en, arr_shift_en
  );

  modport slave (
    input  start, num_rows, w_valid, a_valid,
    output busy, done, w_rd_en, w_row, arr_load_w, a_rd_en, arr_shift_en
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Systolic tile-pass sequencer. It loads HEIGHT weight rows, then streams num_rows activation
// vectors, then drains the array pipeline for WIDTH+HEIGHT-1 cycles, then pulses done.
module systolic_seq_ctrl #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int RW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  systolic_seq_ctrl_if.slave bus
);
  localparam int WW = $clog2(HEIGHT);
  localparam int DW = $clog2(WIDTH + HEIGHT);
  localparam logic [WW-1:0] W_LAST = WW'(HEIGHT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(WIDTH + HEIGHT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [RW-1:0] acnt_q, acnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rows_q, rows_d;

  // NOTE: every signal written here gets a default first; a missed branch then cannot infer a latch.
  always_comb begin
    state_d          = state_q;
    wcnt_d           = wcnt_q;
    acnt_d           = acnt_q;
    dcnt_d           = dcnt_q;
    rows_d           = rows_q;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.w_rd_en      = 1'b0;
    bus.w_row        = '0;
    bus.arr_load_w   = 1'b0;
    bus.a_rd_en      = 1'b0;
    bus.arr_shift_en = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.num_rows != '0)) begin
          state_d = S_LOAD_W;
          rows_d  = bus.num_rows;
          wcnt_d  = '0;
        end
      end
      S_LOAD_W: begin
        bus.busy       = 1'b1;
        bus.w_rd_en    = bus.w_valid;
        bus.arr_load_w = bus.w_valid;
        bus.w_row      = wcnt_q;
        if (bus.w_valid) begin
          if (wcnt_q == W_LAST) begin
            state_d = S_STREAM;
            acnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        bus.busy         = 1'b1;
        bus.a_rd_en      = bus.a_valid;
        bus.arr_shift_en = bus.a_valid;
        if (bus.a_valid) begin
          if (acnt_q == rows_q - RW'(1)) begin
            state_d = S_DRAIN;
            dcnt_d  = '0;
          end else begin
            acnt_d = acnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The pipeline flushes on a fixed schedule. Buffer valids play no part here.
        bus.busy         = 1'b1;
        bus.arr_shift_en = 1'b1;
        if (dcnt_q == D_LAST) state_d = S_DONE;
        else                  dcnt_d  = dcnt_q + 1'b1;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      acnt_q  <= '0;
      dcnt_q  <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
      rows_q  <= rows_d;
    end
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with WIDTH=HEIGHT=4 and RW=8.
// Cycle 0 is the cycle in which start is presented.
module tb_systolic_seq_ctrl;
  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   wpops;
  int   apops;

  systolic_seq_ctrl_if #(.HEIGHT(4), .RW(8)) bus ();

  systolic_seq_ctrl #(.WIDTH(4), .HEIGHT(4), .RW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output vector order: {busy, done, w_rd_en, arr_load_w, w_row[1:0], a_rd_en, arr_shift_en}
  task automatic exp_out(input string tag, input int c, input bit busy, input bit done,
                         input bit wrd, input bit load, input logic [1:0] row,
                         input bit ard, input bit shift);
    logic [8:0] obs;
    logic [8:0] want;
    obs  = {bus.busy, bus.done, bus.w_rd_en, bus.arr_load_w, bus.w_row, bus.a_rd_en, bus.arr_shift_en};
    want = {busy, done, wrd, load, row, ard, shift};
    check($sformatf("%s c%0d outs", tag, c), 32'(obs), 32'(want));
    wpops += int'(bus.w_rd_en);
    apops += int'(bus.a_rd_en);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_rows = '0;
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    tick();
    tick();
    #2;
    exp_out(tag, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    rst = 1'b0;
    wpops = 0;
    apops = 0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;

    // Test 1: a pass with no stalls and num_rows=3.
    do_reset("t1 reset");
    tick();
    bus.start = 1'b1; bus.num_rows = 8'd3; bus.w_valid = 1'b1; bus.a_valid = 1'b1;
    #2; exp_out("t1", 0, 0, 0, 0, 0, 2'd0, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      tick(); bus.start = 1'b0; #2;
      exp_out("t1", c, c <= 15, c == 15, c <= 4, c <= 4, (c <= 4) ? 2'(c - 1) : 2'd0,
              c >= 5 && c <= 7, c >= 5 && c <= 14);
    end
    check("t1 wpops", 32'(wpops), 32'd4);
    check("t1 apops", 32'(apops), 32'd3);

    // Test 2: w_valid is low in cycles 2 and 3, so the weight load stalls.
    do_reset("t2 reset");
    tick();
    bus.start = 1'b1; bus.num_rows = 8'd3; bus.w_valid = 1'b1; bus.a_valid = 1'b1;
    #2; exp_out("t2", 0, 0, 0, 0, 0, 2'd0, 0, 0);
    for (int c = 1; c <= 18; c++) begin
      tick(); bus.start = 1'b0; bus.w_valid = !(c == 2 || c == 3); #2;
      exp_out("t2", c, c <= 17, c == 17, c == 1 || (c >= 4 && c <= 6), c == 1 || (c >= 4 && c <= 6),
              (c == 1) ? 2'd0 : (c <= 4) ? 2'd1 : (c == 5) ? 2'd2 : (c == 6) ? 2'd3 : 2'd0,
              c >= 7 && c <= 9, c >= 7 && c <= 16);
    end
    check("t2 wpops", 32'(wpops), 32'd4);

    // Test 3: a_valid toggles during STREAM and is held high outside STREAM.
    do_reset("t3 reset");
    tick();
    bus.start = 1'b1; bus.num_rows = 8'd3; bus.w_valid = 1'b1; bus.a_valid = 1'b1;
    #2; exp_out("t3", 0, 0, 0, 0, 0, 2'd0, 0, 0);
    for (int c = 1; c <= 18; c++) begin
      tick(); bus.start = 1'b0;
      bus.a_valid = (c >= 5 && c <= 9) ? (c % 2 == 1) : 1'b1;
      #2;
      exp_out("t3", c, c <= 17, c == 17, c <= 4, c <= 4, (c <= 4) ? 2'(c - 1) : 2'd0,
              c == 5 || c == 7 || c == 9, c == 5 || c == 7 || (c >= 9 && c <= 16));
    end
    check("t3 apops", 32'(apops), 32'd3);

    // Test 4: start with num_rows=0 must be ignored.
    // Start during STREAM must be ignored. Start during DONE must be ignored.
    do_reset("t4 reset");
    for (int c = 0; c <= 2; c++) begin
      tick(); bus.start = (c < 2); bus.num_rows = 8'd0; #2;
      exp_out("t4 zero", c, 0, 0, 0, 0, 2'd0, 0, 0);
    end
    bus.start = 1'b1; bus.num_rows = 8'd3; bus.w_valid = 1'b1; bus.a_valid = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      bus.start = (c == 6 || c == 15);
      bus.num_rows = (c == 6) ? 8'd1 : (c == 15) ? 8'd5 : 8'd3;
      #2;
      exp_out("t4", c, c <= 15, c == 15, c <= 4, c <= 4, (c <= 4) ? 2'(c - 1) : 2'd0,
              c >= 5 && c <= 7, c >= 5 && c <= 14);
    end
    check("t4 apops", 32'(apops), 32'd3);

    // Test 5: reset in STREAM after one activation pop, followed by a clean pass with num_rows=2.
    do_reset("t5 reset");
    tick();
    bus.start = 1'b1; bus.num_rows = 8'd3; bus.w_valid = 1'b1; bus.a_valid = 1'b1;
    #2; exp_out("t5a", 0, 0, 0, 0, 0, 2'd0, 0, 0);
    for (int c = 1; c <= 18; c++) begin
      tick(); bus.start = 1'b0;
      bus.a_valid = (c != 6);
      rst = (c == 6);
      #2;
      exp_out("t5a", c, c <= 6, 0, c <= 4, c <= 4, (c <= 4) ? 2'(c - 1) : 2'd0, c == 5, c == 5);
    end
    wpops = 0; apops = 0;
    tick();
    bus.start = 1'b1; bus.num_rows = 8'd2;
    #2; exp_out("t5b", 0, 0, 0, 0, 0, 2'd0, 0, 0);
    for (int c = 1; c <= 15; c++) begin
      tick(); bus.start = 1'b0; #2;
      exp_out("t5b", c, c <= 14, c == 14, c <= 4, c <= 4, (c <= 4) ? 2'(c - 1) : 2'd0,
              c >= 5 && c <= 6, c >= 5 && c <= 13);
    end
    check("t5 wpops", 32'(wpops), 32'd4);
    check("t5 apops", 32'(apops), 32'd2);

    // Test 6: start held high gives back-to-back passes with num_rows=1.
    do_reset("t6 reset");
    tick();
    bus.start = 1'b1; bus.num_rows = 8'd1; bus.w_valid = 1'b1; bus.a_valid = 1'b1;
    #2; exp_out("t6", 0, 0, 0, 0, 0, 2'd0, 0, 0);
    for (int c = 1; c <= 29; c++) begin
      tick(); bus.start = (c < 15); #2;
      exp_out("t6", c, (c >= 1 && c <= 13) || (c >= 15 && c <= 27), c == 13 || c == 27,
              c <= 4 || (c >= 15 && c <= 18), c <= 4 || (c >= 15 && c <= 18),
              (c <= 4) ? 2'(c - 1) : (c >= 15 && c <= 18) ? 2'(c - 15) : 2'd0,
              c == 5 || c == 19, (c >= 5 && c <= 12) || (c >= 19 && c <= 26));
    end
    check("t6 wpops", 32'(wpops), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
